execute_stage: RTL

//   Execute stage fed directly by the decode/execute pipeline buffer: operand forwarding, 16-bit ALU,

---
 rtl/execute_stage.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/execute_stage.sv
// rtl/execute_stage.sv - execute stage: forwarding, 16-bit ALU, CCR, branch resolution
// All state is captured on the falling clock edge to line up with the pipeline buffers.
module execute_stage #(
  parameter int DW  = 16,
  parameter int PCW = 32
) (
  input  logic           Clk,
  input  logic           Rst,
  input  logic           stall,
  input  logic [1:0]     FlashNumIn,
  input  logic [3:0]     aluSignals,
  input  logic [DW-1:0]  Reg1,
  input  logic [DW-1:0]  Reg2,
  input  logic [DW-1:0]  instr,
  input  logic           ALU_src,
  input  logic [1:0]     fwdA,
  input  logic [1:0]     fwdB,
  input  logic [DW-1:0]  emResult,
  input  logic [DW-1:0]  wbResult,
  input  logic           MR,
  input  logic           MW,
  input  logic           MTR,
  input  logic           RW,
  input  logic [2:0]     RegDestination,
  input  logic           Branch,
  input  logic [1:0]     brCond,
  input  logic           SetC,
  input  logic           CLRC,
  input  logic [PCW-1:0] pc,
  output logic [DW-1:0]  resultOut,
  output logic [DW-1:0]  storeDataOut,
  output logic           MROut,
  output logic           MWOut,
  output logic           MTROut,
  output logic           RWOut,
  output logic [2:0]     RegDestinationOut,
  output logic [PCW-1:0] pcOut,
  output logic [2:0]     flagsOut,
  output logic           branchTaken,
  output logic           branchTarget_unused_guard,
  output logic [DW-1:0]  branchTarget
);

  localparam int C_BIT = 2;
  localparam int N_BIT = 1;
  localparam int Z_BIT = 0;

  logic [DW-1:0]  op_a, fwd_b, op_b;
  logic [DW-1:0]  alu_res;
  logic           zn_upd, c_upd, c_val;
  logic [DW:0]    sum_ext, shl_ext, shr_ext;
  logic           taken;
  logic [2:0]     ccr_d, ccr_q;

  logic [DW-1:0]  res_q, store_q, tgt_q;
  logic [3:0]     ctrl_q;
  logic [2:0]     rd_q;
  logic [PCW-1:0] pc_q;
  logic           taken_q;

  always_comb begin
    case (fwdA)
      2'b01:   op_a = emResult;
      2'b10:   op_a = wbResult;
      default: op_a = Reg1;
    endcase
    case (fwdB)
      2'b01:   fwd_b = emResult;
      2'b10:   fwd_b = wbResult;
      default: fwd_b = Reg2;
    endcase
    op_b = ALU_src ? instr : fwd_b;
  end

  // Shifts go through one extra bit so the last bit shifted out lands in a fixed position.
  always_comb begin
    alu_res = '0;
    zn_upd  = 1'b0;
    c_upd   = 1'b0;
    c_val   = 1'b0;
    sum_ext = '0;
    shl_ext = {1'b0, op_a} << op_b[3:0];
    shr_ext = {op_a, 1'b0} >> op_b[3:0];
    case (aluSignals)
      4'h0: alu_res = op_a;
      4'h1: begin alu_res = ~op_a; zn_upd = 1'b1; end
      4'h2: begin
        sum_ext = {1'b0, op_a} + {{DW{1'b0}}, 1'b1};
        alu_res = sum_ext[DW-1:0];
        zn_upd  = 1'b1; c_upd = 1'b1; c_val = sum_ext[DW];
      end
      4'h3: begin
        alu_res = op_a - {{(DW-1){1'b0}}, 1'b1};
        zn_upd  = 1'b1; c_upd = 1'b1; c_val = (op_a == '0);
      end
      4'h4: begin
        sum_ext = {1'b0, op_a} + {1'b0, op_b};
        alu_res = sum_ext[DW-1:0];
        zn_upd  = 1'b1; c_upd = 1'b1; c_val = sum_ext[DW];
      end
      4'h5: begin
        alu_res = op_a - op_b;
        zn_upd  = 1'b1; c_upd = 1'b1; c_val = (op_a < op_b);
      end
      4'h6: begin alu_res = op_a & op_b; zn_upd = 1'b1; end
      4'h7: begin alu_res = op_a | op_b; zn_upd = 1'b1; end
      4'h8: begin
        alu_res = shl_ext[DW-1:0];
        zn_upd  = 1'b1; c_upd = (op_b[3:0] != 4'h0); c_val = shl_ext[DW];
      end
      4'h9: begin
        alu_res = shr_ext[DW:1];
        zn_upd  = 1'b1; c_upd = (op_b[3:0] != 4'h0); c_val = shr_ext[0];
      end
      4'hA: alu_res = op_b;
      default: alu_res = '0;
    endcase
  end

  always_comb begin
    taken = 1'b0;
    if (Branch) begin
      case (brCond)
        2'b00:   taken = ccr_q[Z_BIT];
        2'b01:   taken = ccr_q[N_BIT];
        2'b10:   taken = ccr_q[C_BIT];
        default: taken = 1'b1;
      endcase
    end
  end

  // Branches never feed ALU flags; a taken conditional consumes its flag; SetC/CLRC win last.
  always_comb begin
    ccr_d = ccr_q;
    if (!Branch) begin
      if (zn_upd) begin
        ccr_d[Z_BIT] = (alu_res == '0);
        ccr_d[N_BIT] = alu_res[DW-1];
      end
      if (c_upd) ccr_d[C_BIT] = c_val;
    end
    if (taken) begin
      case (brCond)
        2'b00:   ccr_d[Z_BIT] = 1'b0;
        2'b01:   ccr_d[N_BIT] = 1'b0;
        2'b10:   ccr_d[C_BIT] = 1'b0;
        default: ;
      endcase
    end
    if (SetC && !CLRC)      ccr_d[C_BIT] = 1'b1;
    else if (CLRC && !SetC) ccr_d[C_BIT] = 1'b0;
  end

  always_ff @(negedge Clk) begin
    if (Rst) begin
      res_q   <= '0;
      store_q <= '0;
      tgt_q   <= '0;
      ctrl_q  <= '0;
      rd_q    <= '0;
      pc_q    <= '0;
      taken_q <= 1'b0;
      ccr_q   <= '0;
    end else if (stall) begin
      ;
    end else if (FlashNumIn != 2'b00) begin
      res_q   <= '0;
      store_q <= '0;
      tgt_q   <= '0;
      ctrl_q  <= '0;
      rd_q    <= '0;
      pc_q    <= '0;
      taken_q <= 1'b0;
    end else begin
      res_q   <= alu_res;
      store_q <= fwd_b;
      tgt_q   <= op_a;
      ctrl_q  <= {MR, MW, MTR, RW};
      rd_q    <= RegDestination;
      pc_q    <= pc;
      taken_q <= taken;
      ccr_q   <= ccr_d;
    end
  end

  assign resultOut                 = res_q;
  assign storeDataOut              = store_q;
  assign branchTarget              = tgt_q;
  assign {MROut, MWOut, MTROut, RWOut} = ctrl_q;
  assign RegDestinationOut         = rd_q;
  assign pcOut                     = pc_q;
  assign branchTaken               = taken_q;
  assign branchTarget_unused_guard = 1'b0;
  assign flagsOut                  = ccr_q;

endmodule
